// File: rtl/adder_pkg.sv
// Shared definitions for the adder job sequencer: FSM state encoding,
// default register map of the remote adder and AXI response codes.
package adder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_A   = 3'd1,
    ST_WR_B   = 3'd2,
    ST_RD_RES = 3'd3,
    ST_RD_OVF = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int DEF_ADDR_OPA = 0;
  localparam int DEF_ADDR_OPB = 4;
  localparam int DEF_ADDR_RES = 8;
  localparam int DEF_ADDR_OVF = 12;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic is_wr_state(input state_e s);
    return (s == ST_WR_A) || (s == ST_WR_B);
  endfunction

  function automatic logic is_rd_state(input state_e s);
    return (s == ST_RD_RES) || (s == ST_RD_OVF);
  endfunction

endpackage

// File: rtl/adder_seq_if.sv
// AXI-Lite bus between the adder sequencer (master) and the adder register
// block (slave).
interface adder_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/adder_seq_wd.sv
// Per-state watchdog: counts cycles spent in the current non-idle state and
// flags expiry on the last allowed cycle so the sequencer can abort.
module adder_seq_wd #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_r;

  // cycles spent in the current state, restarted on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!active || restart) begin
      cnt_r <= '0;
    end else if (!expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = active && (cnt_r == CW'(LIMIT - 1));
endmodule

// File: rtl/adder_seq.sv
// Adder job sequencer: writes two operands to a remote adder over AXI-Lite,
// reads back sum and carry, and reports them with a one-cycle done pulse.
// Optional feature: define ADDER_SEQ_TIMEOUT_EN to abort a job whose current
// state lasts TIMEOUT_CYCLES cycles (timeout pulse, no done).
module adder_seq
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int ADDR_OPA       = DEF_ADDR_OPA,
  parameter int ADDR_OPB       = DEF_ADDR_OPB,
  parameter int ADDR_RES       = DEF_ADDR_RES,
  parameter int ADDR_OVF       = DEF_ADDR_OVF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  m1_axi_aclk,
  input  logic                  m1_axi_aresetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic [1:0]            last_resp,
  output logic                  timeout,
  adder_seq_if.master           m1_axi
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] A_OPA = ADDR_WIDTH'(ADDR_OPA);
  localparam logic [ADDR_WIDTH-1:0] A_OPB = ADDR_WIDTH'(ADDR_OPB);
  localparam logic [ADDR_WIDTH-1:0] A_RES = ADDR_WIDTH'(ADDR_RES);
  localparam logic [ADDR_WIDTH-1:0] A_OVF = ADDR_WIDTH'(ADDR_OVF);

  logic rst_meta_r, rst_sync_r, rst_n_s;
  state_e state_r, state_nxt_s;
  logic state_entry_s, timeout_hit_s;
  logic wr_fin_s, rd_fin_s;

  logic                  awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic [ADDR_WIDTH-1:0] awaddr_r, araddr_r;
  logic [DATA_WIDTH-1:0] wdata_r, op_b_r, res_buf_r, result_r;
  logic [STRB_W-1:0]     wstrb_r;
  logic                  busy_r, done_r, timeout_r, overflow_r;
  logic [1:0]            last_resp_r;

  logic                  awvalid_nxt_s, wvalid_nxt_s, bready_nxt_s, arvalid_nxt_s, rready_nxt_s;
  logic [ADDR_WIDTH-1:0] awaddr_nxt_s, araddr_nxt_s;
  logic [DATA_WIDTH-1:0] wdata_nxt_s, op_b_nxt_s, res_buf_nxt_s, result_nxt_s;
  logic [STRB_W-1:0]     wstrb_nxt_s;
  logic                  busy_nxt_s, done_nxt_s, timeout_nxt_s, overflow_nxt_s;
  logic [1:0]            last_resp_nxt_s;

  // reset asserts asynchronously but is released on the clock
  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end
  assign rst_n_s = rst_sync_r;

  // a channel counts as complete once its valid has dropped or is accepted now
  assign wr_fin_s = (!awvalid_r || m1_axi.awready) && (!wvalid_r || m1_axi.wready) && m1_axi.bvalid;
  assign rd_fin_s = (!arvalid_r || m1_axi.arready) && m1_axi.rvalid;
  assign state_entry_s = (state_nxt_s != state_r);

`ifdef ADDER_SEQ_TIMEOUT_EN
  adder_seq_wd #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (m1_axi_aclk),
    .rst_n   (rst_n_s),
    .active  (state_r != ST_IDLE),
    .restart (state_entry_s),
    .expired (timeout_hit_s)
  );
`else
  assign timeout_hit_s = 1'b0;
`endif

  // state register
  always_ff @(posedge m1_axi_aclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // job sequencing; a watchdog abort overrides every state
  always_comb begin
    state_nxt_s = state_r;
    if (timeout_hit_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = start    ? ST_WR_A   : ST_IDLE;
        ST_WR_A:   state_nxt_s = wr_fin_s ? ST_WR_B   : ST_WR_A;
        ST_WR_B:   state_nxt_s = wr_fin_s ? ST_RD_RES : ST_WR_B;
        ST_RD_RES: state_nxt_s = rd_fin_s ? ST_RD_OVF : ST_RD_RES;
        ST_RD_OVF: state_nxt_s = rd_fin_s ? ST_DONE   : ST_RD_OVF;
        ST_DONE:   state_nxt_s = ST_IDLE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // next values of all registered outputs
  always_comb begin
    awaddr_nxt_s  = awaddr_r;
    wdata_nxt_s   = wdata_r;
    wstrb_nxt_s   = wstrb_r;
    araddr_nxt_s  = araddr_r;
    awvalid_nxt_s = (timeout_hit_s || (awvalid_r && m1_axi.awready)) ? 1'b0 : awvalid_r;
    wvalid_nxt_s  = (timeout_hit_s || (wvalid_r && m1_axi.wready))   ? 1'b0 : wvalid_r;
    arvalid_nxt_s = (timeout_hit_s || (arvalid_r && m1_axi.arready)) ? 1'b0 : arvalid_r;
    // WR_A is only entered from IDLE, so op_a is taken straight from the port
    case (state_entry_s ? state_nxt_s : ST_IDLE)
      ST_WR_A: begin
        awvalid_nxt_s = 1'b1;
        wvalid_nxt_s  = 1'b1;
        awaddr_nxt_s  = A_OPA;
        wdata_nxt_s   = op_a;
        wstrb_nxt_s   = {STRB_W{1'b1}};
      end
      ST_WR_B: begin
        awvalid_nxt_s = 1'b1;
        wvalid_nxt_s  = 1'b1;
        awaddr_nxt_s  = A_OPB;
        wdata_nxt_s   = op_b_r;
        wstrb_nxt_s   = {STRB_W{1'b1}};
      end
      ST_RD_RES: begin
        arvalid_nxt_s = 1'b1;
        araddr_nxt_s  = A_RES;
      end
      ST_RD_OVF: begin
        arvalid_nxt_s = 1'b1;
        araddr_nxt_s  = A_OVF;
      end
      default: begin
        awaddr_nxt_s = awaddr_r;
      end
    endcase
    bready_nxt_s  = is_wr_state(state_nxt_s);
    rready_nxt_s  = is_rd_state(state_nxt_s);
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    done_nxt_s    = (state_nxt_s == ST_DONE);
    timeout_nxt_s = timeout_hit_s;
    op_b_nxt_s    = (state_r == ST_IDLE && start) ? op_b : op_b_r;
    res_buf_nxt_s = (state_r == ST_RD_RES && m1_axi.rvalid) ? m1_axi.rdata : res_buf_r;
    if (state_r == ST_IDLE && start) begin
      last_resp_nxt_s = 2'b00;
    end else if (is_wr_state(state_r) && m1_axi.bvalid) begin
      last_resp_nxt_s = last_resp_r | m1_axi.bresp;
    end else if (is_rd_state(state_r) && m1_axi.rvalid) begin
      last_resp_nxt_s = last_resp_r | m1_axi.rresp;
    end else begin
      last_resp_nxt_s = last_resp_r;
    end
    // published results change only when a job completes
    if (state_r == ST_RD_OVF && state_nxt_s == ST_DONE) begin
      result_nxt_s   = res_buf_r;
      overflow_nxt_s = m1_axi.rdata[0];
    end else begin
      result_nxt_s   = result_r;
      overflow_nxt_s = overflow_r;
    end
  end

  // output and datapath registers
  always_ff @(posedge m1_axi_aclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awaddr_r    <= '0;
      araddr_r    <= '0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      op_b_r      <= '0;
      res_buf_r   <= '0;
      result_r    <= '0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      last_resp_r <= 2'b00;
    end else begin
      awvalid_r   <= awvalid_nxt_s;
      wvalid_r    <= wvalid_nxt_s;
      bready_r    <= bready_nxt_s;
      arvalid_r   <= arvalid_nxt_s;
      rready_r    <= rready_nxt_s;
      awaddr_r    <= awaddr_nxt_s;
      araddr_r    <= araddr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      wstrb_r     <= wstrb_nxt_s;
      op_b_r      <= op_b_nxt_s;
      res_buf_r   <= res_buf_nxt_s;
      result_r    <= result_nxt_s;
      overflow_r  <= overflow_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      timeout_r   <= timeout_nxt_s;
      last_resp_r <= last_resp_nxt_s;
    end
  end

  assign m1_axi.awvalid = awvalid_r;
  assign m1_axi.awaddr  = awaddr_r;
  assign m1_axi.wvalid  = wvalid_r;
  assign m1_axi.wdata   = wdata_r;
  assign m1_axi.wstrb   = wstrb_r;
  assign m1_axi.bready  = bready_r;
  assign m1_axi.arvalid = arvalid_r;
  assign m1_axi.araddr  = araddr_r;
  assign m1_axi.rready  = rready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign timeout   = timeout_r;
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign last_resp = last_resp_r;
endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq: an AXI-Lite slave that really adds the two written
// operands, directed vectors, randomized jobs against an arithmetic model,
// and hand-written sequences for busy-start, mid-job reset and timeout.
module tb_adder_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'h0, op_b = 32'h0;
  logic        busy, done, overflow, timeout;
  logic [31:0] result;
  logic [1:0]  last_resp;
  int n_vec = 0, n_err = 0;

  adder_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) axi ();

  adder_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .last_resp(last_resp), .timeout(timeout), .m1_axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    int aw, w, bd, ar, r;
    logic [1:0] bresp, rresp;
    logic [31:0] exp_res;
    logic exp_ovf;
    logic [1:0] exp_resp;
    int exp_lat;
  } vec_t;

  vec_t tbl[6];

  // slave configuration and state
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] mem_a = 32'h0, mem_b = 32'h0;
  logic [32:0] sum_q;
  bit aw_got, w_got, b_pend, r_pend;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [7:0] wr_addr_q, rd_addr_q, p_awaddr, p_araddr;
  logic [31:0] wr_data_q, p_wdata;
  logic [3:0] p_wstrb;
  bit p_awvalid, p_wvalid, p_arvalid, p_aw_fire, p_w_fire, p_b_fire, p_ar_fire, p_r_fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI-Lite slave with programmable delays; also watches master-side rules
  initial begin : slave
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
        p_aw_fire = 0; p_w_fire = 0; p_b_fire = 0; p_ar_fire = 0; p_r_fire = 0;
      end else begin
        if (timeout !== 1'b1) begin
          if (p_awvalid && !p_aw_fire) check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
          if (p_aw_fire) check("aw_drop", axi.awvalid, 1'b0);
          if (p_wvalid && !p_w_fire) check("w_hold", {axi.wvalid, axi.wdata}, {1'b1, p_wdata});
          if (p_w_fire) check("w_drop", axi.wvalid, 1'b0);
          if (p_arvalid && !p_ar_fire) check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
          if (p_ar_fire) check("ar_drop", axi.arvalid, 1'b0);
        end
        if (p_aw_fire) begin aw_got = 1; wr_addr_q = p_awaddr; axi.awready = 1'b0; aw_cnt = 0; end
        if (p_w_fire) begin
          w_got = 1; wr_data_q = p_wdata; axi.wready = 1'b0; w_cnt = 0;
          check("wstrb", p_wstrb, 4'hF);
        end
        if (p_b_fire) axi.bvalid = 1'b0;
        if (p_ar_fire) begin r_pend = 1; rd_addr_q = p_araddr; r_cnt = 0; axi.arready = 1'b0; ar_cnt = 0; end
        if (p_r_fire) axi.rvalid = 1'b0;
        if (aw_got && w_got) begin
          if (wr_addr_q == 8'd0) mem_a = wr_data_q;
          else if (wr_addr_q == 8'd4) mem_b = wr_data_q;
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (axi.awvalid && !axi.awready) begin
          if (aw_cnt >= aw_dly) axi.awready = 1'b1; else aw_cnt++;
        end
        if (axi.wvalid && !axi.wready) begin
          if (w_cnt >= w_dly) axi.wready = 1'b1; else w_cnt++;
        end
        if (axi.arvalid && !axi.arready) begin
          if (ar_cnt >= ar_dly) axi.arready = 1'b1; else ar_cnt++;
        end
        if (b_pend && !axi.bvalid) begin
          if (b_cnt >= b_dly) begin axi.bvalid = 1'b1; axi.bresp = bresp_cfg; b_pend = 0; end
          else b_cnt++;
        end
        if (r_pend && !axi.rvalid) begin
          if (r_cnt >= r_dly) begin
            sum_q = {1'b0, mem_a} + {1'b0, mem_b};
            if (rd_addr_q == 8'd8) axi.rdata = sum_q[31:0];
            else if (rd_addr_q == 8'd12) axi.rdata = {31'h0, sum_q[32]};
            else axi.rdata = 32'hDEADBEEF;
            axi.rresp = rresp_cfg; axi.rvalid = 1'b1; r_pend = 0;
          end else r_cnt++;
        end
        p_awvalid = axi.awvalid; p_awaddr = axi.awaddr; p_aw_fire = axi.awvalid && axi.awready;
        p_wvalid = axi.wvalid; p_wdata = axi.wdata; p_wstrb = axi.wstrb; p_w_fire = axi.wvalid && axi.wready;
        p_arvalid = axi.arvalid; p_araddr = axi.araddr; p_ar_fire = axi.arvalid && axi.arready;
        p_b_fire = axi.bvalid && axi.bready;
        p_r_fire = axi.rvalid && axi.rready;
      end
    end
  end

  task automatic run_job(input vec_t v);
    int cyc;
    @(negedge clk);
    aw_dly = v.aw; w_dly = v.w; b_dly = v.bd; ar_dly = v.ar; r_dly = v.r;
    bresp_cfg = v.bresp; rresp_cfg = v.rresp;
    start = 1'b1; op_a = v.a; op_b = v.b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    cyc = 1;
    check("busy_after_start", busy, 1'b1);
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, v.exp_lat);
    check("result", result, v.exp_res);
    check("overflow", overflow, v.exp_ovf);
    check("last_resp", last_resp, v.exp_resp);
    check("written_ops", {mem_a, mem_b}, {v.a, v.b});
    @(negedge clk);
    check("done_one_cycle", {done, busy}, 2'b00);
  endtask

  initial begin : main
    vec_t v;
    int cyc, dones, first_done, mx;
    logic [32:0] s;
    tbl[0] = '{32'd5, 32'd7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd12, 1'b0, 2'b00, 9};
    tbl[1] = '{32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1, 2'b00, 9};
    tbl[2] = '{32'h12345678, 32'h11111111, 0, 3, 2, 0, 0, 2'b00, 2'b00, 32'h23456789, 1'b0, 2'b00, 19};
    tbl[3] = '{32'h80000000, 32'h80000000, 2, 0, 0, 1, 2, 2'b10, 2'b00, 32'h0, 1'b1, 2'b10, 19};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'hFFFFFFFE, 1'b1, 2'b01, 9};
    tbl[5] = '{32'h0, 32'h0, 1, 1, 1, 1, 1, 2'b00, 2'b00, 32'h0, 1'b0, 2'b00, 17};

    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, timeout, overflow, last_resp, axi.awvalid, axi.wvalid, axi.bready,
                         axi.arvalid, axi.rready, axi.awaddr, axi.araddr, axi.wstrb}, 31'h0);
    check("reset_data", {result, axi.wdata}, 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.a = (i % 8 == 0) ? 32'hFFFFFFFF : $urandom;
      v.b = $urandom;
      v.aw = $urandom_range(3, 0); v.w = $urandom_range(3, 0); v.bd = $urandom_range(3, 0);
      v.ar = $urandom_range(3, 0); v.r = $urandom_range(3, 0);
      v.bresp = ($urandom_range(3, 0) == 0) ? 2'b10 : 2'b00;
      v.rresp = ($urandom_range(3, 0) == 0) ? 2'b01 : 2'b00;
      s = {1'b0, v.a} + {1'b0, v.b};
      v.exp_res = s[31:0]; v.exp_ovf = s[32]; v.exp_resp = v.bresp | v.rresp;
      mx = (v.aw > v.w) ? v.aw : v.w;
      v.exp_lat = 1 + 2 * (mx + v.bd + 2) + 2 * (v.ar + v.r + 2);
      run_job(v);
    end

    // start pulses while busy (mid-job and in the DONE cycle) are ignored
    @(negedge clk);
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    start = 1'b1; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    dones = 0; first_done = 0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      if (done === 1'b1) begin dones++; first_done = cyc; end
      if (cyc == 3 || cyc == 9) begin start = 1'b1; op_a = 32'd100; op_b = 32'd200; end
      else start = 1'b0;
      @(negedge clk);
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_when", first_done, 9);
    check("busy_start_result", result, 32'd7);
    check("busy_start_ops", {mem_a, mem_b}, {32'd3, 32'd4});

    // reset while waiting in RD_RES
    @(negedge clk);
    ar_dly = 20;
    start = 1'b1; op_a = 32'd9; op_b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(axi.arvalid === 1'b1 && axi.araddr === 8'd8) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_rd_res", axi.arvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {busy, done, timeout, overflow, last_resp, axi.awvalid, axi.wvalid, axi.bready,
                            axi.arvalid, axi.rready, axi.awaddr, axi.araddr, axi.wstrb}, 31'h0);
    check("midreset_data", {result, axi.wdata}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ar_dly = 0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("no_done_after_reset", dones, 0);
    run_job(tbl[0]);

`ifdef ADDER_SEQ_TIMEOUT_EN
    // arready withheld: RD_RES is abandoned after 255 cycles
    @(negedge clk);
    ar_dly = 100000;
    start = 1'b1; op_a = 32'd1; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; dones = 0;
    while (timeout !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) dones++;
    end
    check("timeout_when", cyc, 260);
    check("timeout_no_done", dones, 0);
    check("timeout_outputs", {busy, axi.arvalid, axi.rready}, 3'b000);
    @(negedge clk);
    check("timeout_pulse", {timeout, busy, done}, 3'b000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
